// File: rtl/rs_issue_queue_pkg.sv
// Shared types for the reservation-station issue queue: entry record, CDB broadcast,
// station/ROB index types and the wakeup helper used on stored and incoming entries.
package rs_issue_queue_pkg;

    localparam int unsigned RS_SIZE  = 4;
    localparam int unsigned ROB_SIZE = 16;

    typedef logic [$clog2(RS_SIZE)-1:0]  ResSize;
    typedef logic [$clog2(ROB_SIZE)-1:0] RobSize;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       use_imm;
    } control_bits;

    // tag_k == 0 means value_k already holds the operand.
    typedef struct packed {
        control_bits ctrl;
        RobSize      tag;
        RobSize      tag_1;
        RobSize      tag_2;
        logic [31:0] value_1;
        logic [31:0] value_2;
    } rs_entry;

    typedef struct packed {
        RobSize      tag;
        logic [31:0] value;
    } cdb;

    typedef enum logic [0:0] {StEmpty, StHold} iss_state_e;

    // Capture any pending operand broadcast on either CDB; cdb1 takes precedence.
    function automatic rs_entry wake(rs_entry e, cdb c1, cdb c2);
        rs_entry r;
        r = e;
        if (e.tag_1 != '0) begin
            if (e.tag_1 == c1.tag) begin
                r.value_1 = c1.value;
                r.tag_1   = '0;
            end else if (e.tag_1 == c2.tag) begin
                r.value_1 = c2.value;
                r.tag_1   = '0;
            end
        end
        if (e.tag_2 != '0) begin
            if (e.tag_2 == c1.tag) begin
                r.value_2 = c1.value;
                r.tag_2   = '0;
            end else if (e.tag_2 == c2.tag) begin
                r.value_2 = c2.value;
                r.tag_2   = '0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_issue_queue_if.sv
// Dispatch, CDB snoop and issue handshake bundle of the issue queue.
// slave = the queue itself, master = the surrounding pipeline.
interface rs_issue_queue_if #(
    parameter int unsigned NUM_RS = 4,
    parameter int unsigned SEL_W  = $clog2(NUM_RS)
) ();
    import rs_issue_queue_pkg::*;

    logic              disp_valid;
    logic [SEL_W-1:0]  disp_id;
    rs_entry           disp_entry;
    cdb                cdb1;
    cdb                cdb2;
    logic [NUM_RS-1:0] rs_busy;
    logic              rs_full;
    logic [SEL_W:0]    free_count;
    logic              disp_err;
    logic              issue_valid;
    rs_entry           issue_entry;
    logic [SEL_W-1:0]  issue_id;
    logic              issue_ready;

    modport slave (
        input  disp_valid, disp_id, disp_entry, cdb1, cdb2, issue_ready,
        output rs_busy, rs_full, free_count, disp_err, issue_valid, issue_entry, issue_id
    );

    modport master (
        output disp_valid, disp_id, disp_entry, cdb1, cdb2, issue_ready,
        input  rs_busy, rs_full, free_count, disp_err, issue_valid, issue_entry, issue_id
    );

endinterface

// File: rtl/rs_issue_queue_age_select.sv
// Combinational oldest-ready picker over an age matrix where age[i][j] = 1 means i is older
// than j. The matrix is acyclic among live entries, so at most one candidate survives.
module rs_age_select #(
    parameter int unsigned NUM_RS = 4,
    parameter int unsigned SEL_W  = $clog2(NUM_RS)
) (
    input  logic [NUM_RS-1:0]             ready,
    input  logic [NUM_RS-1:0][NUM_RS-1:0] age,
    output logic                          sel_valid,
    output logic [SEL_W-1:0]              sel_id
);

    logic [NUM_RS-1:0] cand;

    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            cand[i] = ready[i];
            for (int j = 0; j < NUM_RS; j++) begin
                if (ready[j] && age[j][i]) begin
                    cand[i] = 1'b0;
                end
            end
        end
    end

    // One-hot candidate, so OR-encoding the index is exact.
    always_comb begin
        sel_id = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (cand[i]) begin
                sel_id = sel_id | SEL_W'(i);
            end
        end
    end

    assign sel_valid = |ready;

endmodule

// File: rtl/rs_issue_queue.sv
// Reservation-station array: stores dispatched entries, wakes operands from two CDBs and
// hands the oldest ready entry to execute through a one-deep EMPTY/HOLD issue register.
module rs_issue_queue
    import rs_issue_queue_pkg::*;
#(
    parameter int unsigned NUM_RS = RS_SIZE,
    parameter int unsigned SEL_W  = $clog2(NUM_RS)
) (
    input logic           clk,
    input logic           reset,
    input logic           flush,
    rs_issue_queue_if.slave bus
);

    logic                          squash;
    logic [NUM_RS-1:0]             busy_q, busy_d;
    rs_entry                       ent_q [NUM_RS];
    rs_entry                       ent_d [NUM_RS];
    logic [NUM_RS-1:0][NUM_RS-1:0] age_q, age_d;
    logic [NUM_RS-1:0]             ready;
    logic                          sel_valid;
    logic [SEL_W-1:0]              sel_id;
    logic                          disp_ok;
    logic                          load_issue;
    iss_state_e                    state_q, state_d;
    rs_entry                       issue_entry_q;
    logic [SEL_W-1:0]              issue_id_q;
    logic                          disp_err_q;
    logic [SEL_W:0]                busy_cnt;

    assign squash  = reset || flush;
    assign disp_ok = bus.disp_valid && !busy_q[bus.disp_id];

    always_comb begin
        for (int i = 0; i < NUM_RS; i++) begin
            ready[i] = busy_q[i] && (ent_q[i].tag_1 == '0) && (ent_q[i].tag_2 == '0);
        end
    end

    rs_age_select #(
        .NUM_RS (NUM_RS),
        .SEL_W  (SEL_W)
    ) u_age_select (
        .ready     (ready),
        .age       (age_q),
        .sel_valid (sel_valid),
        .sel_id    (sel_id)
    );

    always_ff @(posedge clk) begin
        if (squash) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (sel_valid) state_d = StHold;
            StHold:  if (bus.issue_ready && !sel_valid) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        load_issue = sel_valid && ((state_q == StEmpty) || bus.issue_ready);
    end

    // Station array next state: wakeup, free on issue, allocate on dispatch.
    always_comb begin
        busy_d = busy_q;
        age_d  = age_q;
        for (int i = 0; i < NUM_RS; i++) begin
            ent_d[i] = busy_q[i] ? wake(ent_q[i], bus.cdb1, bus.cdb2) : ent_q[i];
        end
        if (load_issue) begin
            busy_d[sel_id] = 1'b0;
        end
        if (disp_ok) begin
            busy_d[bus.disp_id] = 1'b1;
            ent_d[bus.disp_id]  = wake(bus.disp_entry, bus.cdb1, bus.cdb2);
            for (int i = 0; i < NUM_RS; i++) begin
                age_d[i][bus.disp_id] = busy_q[i];
            end
            age_d[bus.disp_id] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (squash) begin
            busy_q        <= '0;
            age_q         <= '0;
            disp_err_q    <= 1'b0;
            issue_entry_q <= '0;
            issue_id_q    <= '0;
            for (int i = 0; i < NUM_RS; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            age_q      <= age_d;
            ent_q      <= ent_d;
            disp_err_q <= bus.disp_valid && busy_q[bus.disp_id];
            if (load_issue) begin
                issue_entry_q <= ent_q[sel_id];
                issue_id_q    <= sel_id;
            end
        end
    end

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            busy_cnt = busy_cnt + (SEL_W+1)'(busy_q[i]);
        end
    end

    assign bus.rs_busy     = busy_q;
    assign bus.rs_full     = &busy_q;
    assign bus.free_count  = (SEL_W+1)'(NUM_RS) - busy_cnt;
    assign bus.disp_err    = disp_err_q;
    assign bus.issue_valid = (state_q == StHold);
    assign bus.issue_entry = issue_entry_q;
    assign bus.issue_id    = issue_id_q;

endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue: expected issues are queued at dispatch time and a
// negedge monitor pops and compares every accepted issue transfer.
module tb_rs_issue_queue;
    import rs_issue_queue_pkg::*;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [1:0]  id;
    } exp_t;

    logic clk;
    logic reset;
    logic flush;
    int   checks;
    int   errors;
    exp_t exp_q [$];
    exp_t mon_e;

    rs_issue_queue_if #(.NUM_RS(4), .SEL_W(2)) bus ();

    rs_issue_queue #(.NUM_RS(4), .SEL_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic rs_entry mk(input logic [3:0] tag, input logic [3:0] t1,
                                   input logic [3:0] t2, input logic [31:0] v1,
                                   input logic [31:0] v2);
        rs_entry e;
        e         = '0;
        e.tag     = tag;
        e.tag_1   = t1;
        e.tag_2   = t2;
        e.value_1 = v1;
        e.value_2 = v2;
        return e;
    endfunction

    task automatic expect_issue(input logic [3:0] tag, input logic [31:0] v1,
                                input logic [31:0] v2, input logic [1:0] id);
        exp_t e;
        e.tag = tag;
        e.v1  = v1;
        e.v2  = v2;
        e.id  = id;
        exp_q.push_back(e);
    endtask

    task automatic dispatch(input logic [1:0] id, input rs_entry e);
        bus.disp_valid = 1'b1;
        bus.disp_id    = id;
        bus.disp_entry = e;
        tick();
        bus.disp_valid = 1'b0;
    endtask

    task automatic squash_test(input bit use_reset);
        bus.issue_ready = 1'b0;
        dispatch(2'd0, mk(4'd1, 4'd0, 4'd0, 32'h1, 32'h1));
        dispatch(2'd1, mk(4'd2, 4'd14, 4'd0, 32'h0, 32'h0));
        dispatch(2'd2, mk(4'd3, 4'd14, 4'd0, 32'h0, 32'h0));
        dispatch(2'd3, mk(4'd4, 4'd14, 4'd0, 32'h0, 32'h0));
        dispatch(2'd0, mk(4'd5, 4'd14, 4'd0, 32'h0, 32'h0));
        check("sq_pre_busy", bus.rs_busy, 4'hf);
        check("sq_pre_valid", bus.issue_valid, 1'b1);
        if (use_reset) reset = 1'b1;
        else flush = 1'b1;
        bus.disp_valid = 1'b1;
        bus.disp_id    = 2'd1;
        bus.disp_entry = mk(4'd6, 4'd0, 4'd0, 32'h6, 32'h6);
        tick();
        reset          = 1'b0;
        flush          = 1'b0;
        bus.disp_valid = 1'b0;
        check("sq_busy", bus.rs_busy, 4'h0);
        check("sq_valid", bus.issue_valid, 1'b0);
        check("sq_free", bus.free_count, 3'd4);
        check("sq_full", bus.rs_full, 1'b0);
        check("sq_err", bus.disp_err, 1'b0);
        check("sq_entry_tag", bus.issue_entry.tag, 4'd0);
        check("sq_entry_v1", bus.issue_entry.value_1, 32'h0);
        tick();
        check("sq_post_valid", bus.issue_valid, 1'b0);
        check("sq_post_busy", bus.rs_busy, 4'h0);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.issue_valid && bus.issue_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue actual_tag=%0h required=none", bus.issue_entry.tag);
            end else begin
                mon_e = exp_q.pop_front();
                check("issue_tag", bus.issue_entry.tag, mon_e.tag);
                check("issue_v1", bus.issue_entry.value_1, mon_e.v1);
                check("issue_v2", bus.issue_entry.value_2, mon_e.v2);
                check("issue_tags0", {bus.issue_entry.tag_1, bus.issue_entry.tag_2}, 8'h0);
                check("issue_id", bus.issue_id, mon_e.id);
            end
        end
    end

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        flush           = 1'b0;
        bus.disp_valid  = 1'b0;
        bus.disp_id     = '0;
        bus.disp_entry  = '0;
        bus.cdb1        = '0;
        bus.cdb2        = '0;
        bus.issue_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", bus.rs_busy, 4'h0);
        check("rst_free", bus.free_count, 3'd4);
        check("rst_full", bus.rs_full, 1'b0);
        check("rst_valid", bus.issue_valid, 1'b0);
        check("rst_err", bus.disp_err, 1'b0);

        // Ready dispatch issues one cycle later.
        bus.issue_ready = 1'b1;
        expect_issue(4'd3, 32'h5, 32'h7, 2'd0);
        dispatch(2'd0, mk(4'd3, 4'd0, 4'd0, 32'h5, 32'h7));
        check("t1_busy", bus.rs_busy, 4'h1);
        check("t1_valid_early", bus.issue_valid, 1'b0);
        tick();
        check("t1_valid", bus.issue_valid, 1'b1);
        check("t1_busy_freed", bus.rs_busy, 4'h0);
        tick();
        check("t1_empty", bus.issue_valid, 1'b0);

        // Operand wakeup from cdb1; unrelated cdb2 tag ignored.
        expect_issue(4'd8, 32'h55, 32'h22, 2'd2);
        dispatch(2'd2, mk(4'd8, 4'd4, 4'd0, 32'h0, 32'h22));
        check("t2_busy", bus.rs_busy, 4'h4);
        tick();
        check("t2_wait", bus.issue_valid, 1'b0);
        bus.cdb1 = '{tag: 4'd4, value: 32'h55};
        bus.cdb2 = '{tag: 4'd9, value: 32'h99};
        tick();
        bus.cdb1 = '0;
        bus.cdb2 = '0;
        check("t2_wake_edge", bus.issue_valid, 1'b0);
        tick();
        check("t2_valid", bus.issue_valid, 1'b1);
        tick();
        check("t2_empty", bus.issue_valid, 1'b0);

        // Stall holds the issue register; release gives back-to-back issue.
        bus.issue_ready = 1'b0;
        expect_issue(4'd5, 32'h50, 32'h51, 2'd1);
        expect_issue(4'd6, 32'h60, 32'h61, 2'd0);
        dispatch(2'd1, mk(4'd5, 4'd0, 4'd0, 32'h50, 32'h51));
        dispatch(2'd0, mk(4'd6, 4'd0, 4'd0, 32'h60, 32'h61));
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_valid", bus.issue_valid, 1'b1);
            check("t3_hold_tag", bus.issue_entry.tag, 4'd5);
            tick();
        end
        bus.issue_ready = 1'b1;
        tick();
        check("t3_b2b_valid", bus.issue_valid, 1'b1);
        check("t3_b2b_tag", bus.issue_entry.tag, 4'd6);
        tick();
        check("t3_empty", bus.issue_valid, 1'b0);

        // Oldest-first among several ready stations, independent of index.
        bus.issue_ready = 1'b0;
        expect_issue(4'd13, 32'hd, 32'h0, 2'd0);
        expect_issue(4'd10, 32'ha, 32'h0, 2'd3);
        expect_issue(4'd11, 32'hb, 32'h0, 2'd2);
        expect_issue(4'd12, 32'hc, 32'h0, 2'd1);
        dispatch(2'd0, mk(4'd13, 4'd0, 4'd0, 32'hd, 32'h0));
        dispatch(2'd3, mk(4'd10, 4'd0, 4'd0, 32'ha, 32'h0));
        dispatch(2'd2, mk(4'd11, 4'd0, 4'd0, 32'hb, 32'h0));
        dispatch(2'd1, mk(4'd12, 4'd0, 4'd0, 32'hc, 32'h0));
        check("age_busy", bus.rs_busy, 4'he);
        bus.issue_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("age_empty", bus.issue_valid, 1'b0);

        // Full queue, dispatch to busy station rejected.
        bus.issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_issue(4'(i + 1), 32'haa, 32'(i), 2'(i));
            dispatch(2'(i), mk(4'(i + 1), 4'd14, 4'd0, 32'h0, 32'(i)));
        end
        check("t4_full", bus.rs_full, 1'b1);
        check("t4_free", bus.free_count, 3'd0);
        dispatch(2'd0, mk(4'd15, 4'd0, 4'd0, 32'hee, 32'hef));
        check("t4_err", bus.disp_err, 1'b1);
        tick();
        check("t4_err_pulse", bus.disp_err, 1'b0);
        check("t4_no_issue", bus.issue_valid, 1'b0);
        bus.issue_ready = 1'b1;
        bus.cdb1 = '{tag: 4'd14, value: 32'haa};
        tick();
        bus.cdb1 = '0;
        check("t4_wake_edge", bus.issue_valid, 1'b0);
        tick();
        check("t4_valid", bus.issue_valid, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check("t4_empty", bus.issue_valid, 1'b0);
        check("t4_free_after", bus.free_count, 3'd4);

        // Capture on the dispatch cycle itself; cdb1 wins a tag tie.
        bus.cdb2 = '{tag: 4'd7, value: 32'h77};
        expect_issue(4'd9, 32'h11, 32'h77, 2'd2);
        dispatch(2'd2, mk(4'd9, 4'd0, 4'd7, 32'h11, 32'h0));
        bus.cdb2 = '0;
        check("t5_busy", bus.rs_busy, 4'h4);
        tick();
        check("t5_valid", bus.issue_valid, 1'b1);
        check("t5_v2", bus.issue_entry.value_2, 32'h77);
        tick();
        bus.cdb1 = '{tag: 4'd5, value: 32'h10};
        bus.cdb2 = '{tag: 4'd5, value: 32'h20};
        expect_issue(4'd4, 32'h10, 32'h33, 2'd3);
        dispatch(2'd3, mk(4'd4, 4'd5, 4'd0, 32'h0, 32'h33));
        bus.cdb1 = '0;
        bus.cdb2 = '0;
        tick();
        tick();
        check("t5_empty", bus.issue_valid, 1'b0);

        squash_test(1'b0);
        squash_test(1'b1);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
